// File: rtl/cnn_pkg.sv
// Shared CNN types and constants: stream FSM states, pixel type, counter width helper
// and default feature-map geometry derived from the input image and kernel size.
package cnn_pkg;

    localparam int IMGROW      = 28;
    localparam int IMGCOL      = 28;
    localparam int KERNEL_SIZE = 5;
    localparam int PIX_W       = 8;

    localparam int DEF_OUTROW = IMGROW - KERNEL_SIZE + 1;
    localparam int DEF_OUTCOL = IMGCOL - KERNEL_SIZE + 1;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    // A degenerate 1-entry dimension still needs a 1-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc_counter.sv
// Row/column raster counter: advances column on en, wraps to the next row at COLS-1
// and back to [0][0] after the last position. Flags mark end-of-row and last position.
module rc_counter
    import cnn_pkg::*;
#(
    parameter int ROWS = DEF_OUTROW,
    parameter int COLS = DEF_OUTCOL,
    localparam int RW  = cnt_w(ROWS),
    localparam int CW  = cnt_w(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          is_last,
    output logic          is_eol
);

    assign is_eol  = (col == CW'(COLS - 1));
    assign is_last = is_eol && (row == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (is_eol) begin
                col <= '0;
                row <= is_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_out_streamer.sv
// Snapshots the conv_layer feature map on layer_done and streams it row-major, one
// pixel per valid/ready beat. Optional end-of-row flag m_eol with CNN_STREAM_EOL_EN.
module conv_out_streamer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W,
    parameter int OUTROW     = DEF_OUTROW,
    parameter int OUTCOL     = DEF_OUTCOL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] conv_out [0:OUTROW-1][0:OUTCOL-1],
    input  logic                  layer_done,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
`ifdef CNN_STREAM_EOL_EN
    output logic                  m_eol,
`endif
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int RW = cnt_w(OUTROW);
    localparam int CW = cnt_w(OUTCOL);

    stream_state_t state, state_nxt;
    logic [DATA_WIDTH-1:0] snap [0:OUTROW-1][0:OUTCOL-1];

    logic                  armed, armed_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  valid_nxt, busy_nxt, done_nxt, overrun_nxt;
    logic                  capture, cnt_en;
    logic [RW-1:0]         row, row_nxt;
    logic [CW-1:0]         col, col_nxt;
    logic                  is_last, is_eol;

    rc_counter #(.ROWS(OUTROW), .COLS(OUTCOL)) u_rc (
        .clk     (clk),
        .rst     (rst),
        .clr     (capture),
        .en      (cnt_en),
        .row     (row),
        .col     (col),
        .is_last (is_last),
        .is_eol  (is_eol)
    );

    // Index the counter moves to on a transfer; used to prefetch the next pixel.
    assign col_nxt = is_eol ? '0 : col + 1'b1;
    assign row_nxt = is_eol ? (is_last ? '0 : row + 1'b1) : row;

    assign m_last = m_valid && is_last;
`ifdef CNN_STREAM_EOL_EN
    assign m_eol  = m_valid && is_eol;
`endif

    always_comb begin
        state_nxt   = state;
        armed_nxt   = armed;
        data_nxt    = m_data;
        valid_nxt   = m_valid;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        overrun_nxt = overrun;
        capture     = 1'b0;
        cnt_en      = 1'b0;

        if (!layer_done)
            armed_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (layer_done && armed) begin
                    capture   = 1'b1;
                    armed_nxt = 1'b0;
                    data_nxt  = conv_out[0][0];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                // A new frame while draining is flagged and dropped.
                if (layer_done && armed) begin
                    overrun_nxt = 1'b1;
                    armed_nxt   = 1'b0;
                end
                if (m_valid && m_ready) begin
                    cnt_en = 1'b1;
                    if (is_last) begin
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        data_nxt = snap[row_nxt][col_nxt];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            armed      <= armed_nxt;
            m_data     <= data_nxt;
            m_valid    <= valid_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            snap <= conv_out;
    end

endmodule
